// File: rtl/mips_hazard_ctrl_if.sv
// Handshake bundle between the MIPS-lite datapath (master) and the hazard controller (slave).
// Carries the ID-stage decode, branch resolution, and the pipeline control/statistics outputs.
interface mips_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic              id_src1_vld;
  logic [REG_AW-1:0] id_src1;
  logic              id_src2_vld;
  logic [REG_AW-1:0] id_src2;
  logic              id_dst_vld;
  logic [REG_AW-1:0] id_dst;
  logic              id_is_load;
  logic              id_is_halt;
  logic              ex_br_taken;

  logic              pc_stall;
  logic              ifid_stall;
  logic              idex_bubble;
  logic              ifid_flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              halted;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  instr_cnt;
  logic [CNT_W-1:0]  branch_cnt;

  modport master (
    output id_valid, id_src1_vld, id_src1, id_src2_vld, id_src2,
           id_dst_vld, id_dst, id_is_load, id_is_halt, ex_br_taken,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, fwd_a_sel, fwd_b_sel,
           halted, cycle_cnt, stall_cnt, instr_cnt, branch_cnt
  );

  modport slave (
    input  id_valid, id_src1_vld, id_src1, id_src2_vld, id_src2,
           id_dst_vld, id_dst, id_is_load, id_is_halt, ex_br_taken,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, fwd_a_sel, fwd_b_sel,
           halted, cycle_cnt, stall_cnt, instr_cnt, branch_cnt
  );
endinterface

// File: rtl/mips_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS-lite core, with HALT drain and run statistics.
//   state  | meaning
//   RUN    | normal issue; RAW stalls, branch flushes, forwarding active
//   DRAIN  | HALT is past ID; front end frozen while the pipe empties
//   HALTED | HALT retired; controls held, counters frozen until rst
module mips_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32,
  parameter int FWD_EN = 1
) (
  input logic               clk,
  input logic               rst,
  mips_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic              valid;
    logic              dst_vld;
    logic [REG_AW-1:0] dst;
    logic              is_load;
    logic              is_halt;
  } tag_t;

  state_t           state;
  tag_t             id_t, ex_t, mem_t, wb_t;
  logic             halted_r;
  logic [CNT_W-1:0] cycle_r, stall_r, instr_r, branch_r;

  logic id_ok, run, hold, br, raw_stall, stall, use_fwd;
  logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;

  function automatic logic hit(input logic sv, input logic [REG_AW-1:0] s, input tag_t t);
    return sv & t.valid & t.dst_vld & (t.dst == s);
  endfunction

  // Youngest producer wins; a load still in EX cannot forward yet.
  function automatic logic [1:0] pick(input logic m_ex, input logic m_mem, input logic m_wb);
    if (m_ex)       return 2'd1;
    else if (m_mem) return 2'd2;
    else if (m_wb)  return 2'd3;
    else            return 2'd0;
  endfunction

  assign id_ok = bus.id_valid & ~rst;
  assign id_t  = '{valid: id_ok, dst_vld: bus.id_dst_vld, dst: bus.id_dst,
                   is_load: bus.id_is_load, is_halt: bus.id_is_halt};

  assign a_ex  = id_ok & hit(bus.id_src1_vld, bus.id_src1, ex_t);
  assign a_mem = id_ok & hit(bus.id_src1_vld, bus.id_src1, mem_t);
  assign a_wb  = id_ok & hit(bus.id_src1_vld, bus.id_src1, wb_t);
  assign b_ex  = id_ok & hit(bus.id_src2_vld, bus.id_src2, ex_t);
  assign b_mem = id_ok & hit(bus.id_src2_vld, bus.id_src2, mem_t);
  assign b_wb  = id_ok & hit(bus.id_src2_vld, bus.id_src2, wb_t);

  assign raw_stall = (FWD_EN != 0) ? ((a_ex | b_ex) & ex_t.is_load)
                                   : (a_ex | b_ex | a_mem | b_mem);

  assign run     = (state == RUN);
  assign hold    = ~run;
  assign br      = run & bus.ex_br_taken & ~rst;
  assign stall   = run & raw_stall & ~br;
  assign use_fwd = (FWD_EN != 0) & run & ~stall;

  assign bus.pc_stall    = stall | hold;
  assign bus.ifid_stall  = stall | (state == HALTED);
  assign bus.idex_bubble = stall | br | hold;
  assign bus.ifid_flush  = br | hold;
  assign bus.fwd_a_sel   = use_fwd ? pick(a_ex & ~ex_t.is_load, a_mem, a_wb) : 2'd0;
  assign bus.fwd_b_sel   = use_fwd ? pick(b_ex & ~ex_t.is_load, b_mem, b_wb) : 2'd0;

  assign bus.halted     = halted_r;
  assign bus.cycle_cnt  = cycle_r;
  assign bus.stall_cnt  = stall_r;
  assign bus.instr_cnt  = instr_r;
  assign bus.branch_cnt = branch_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      ex_t     <= '0;
      mem_t    <= '0;
      wb_t     <= '0;
      halted_r <= 1'b0;
      cycle_r  <= '0;
      stall_r  <= '0;
      instr_r  <= '0;
      branch_r <= '0;
    end else begin
      wb_t  <= mem_t;
      mem_t <= ex_t;
      ex_t  <= bus.idex_bubble ? '0 : id_t;
      if (state != HALTED) begin
        cycle_r  <= cycle_r + CNT_W'(1);
        stall_r  <= stall_r + CNT_W'(stall);
        branch_r <= branch_r + CNT_W'(br);
        instr_r  <= instr_r + CNT_W'(wb_t.valid);
      end
      case (state)
        RUN:     if (id_t.valid & id_t.is_halt & ~bus.idex_bubble) state <= DRAIN;
        DRAIN:   if (wb_t.valid & wb_t.is_halt) begin
                   state    <= HALTED;
                   halted_r <= 1'b1;
                 end
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed bench for mips_hazard_ctrl: forwarding and non-forwarding instances on one clock/reset.
module tb_mips_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mips_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) ia ();
  mips_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) ib ();

  mips_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .FWD_EN(1)) u_fwd   (.clk(clk), .rst(rst), .bus(ia.slave));
  mips_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .FWD_EN(0)) u_nofwd (.clk(clk), .rst(rst), .bus(ib.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic v, input logic s1v, input logic [4:0] s1, input logic s2v,
                       input logic [4:0] s2, input logic dv, input logic [4:0] d,
                       input logic ld, input logic ht);
    ia.id_valid = v;  ia.id_src1_vld = s1v; ia.id_src1 = s1; ia.id_src2_vld = s2v;
    ia.id_src2 = s2;  ia.id_dst_vld = dv;   ia.id_dst = d;   ia.id_is_load = ld;
    ia.id_is_halt = ht;
  endtask

  task automatic set_b(input logic v, input logic s1v, input logic [4:0] s1, input logic s2v,
                       input logic [4:0] s2, input logic dv, input logic [4:0] d,
                       input logic ld, input logic ht);
    ib.id_valid = v;  ib.id_src1_vld = s1v; ib.id_src1 = s1; ib.id_src2_vld = s2v;
    ib.id_src2 = s2;  ib.id_dst_vld = dv;   ib.id_dst = d;   ib.id_is_load = ld;
    ib.id_is_halt = ht;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ia.ex_br_taken = 1'b0;
    ib.ex_br_taken = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ia.ex_br_taken = 1'b0;
    ib.ex_br_taken = 1'b0;
    #1;
    chk("rst_pc_stall", ia.pc_stall, 0);
    chk("rst_bubble", ia.idex_bubble, 0);
    chk("rst_flush", ia.ifid_flush, 0);
    chk("rst_halted", ia.halted, 0);
    chk("rst_cycle", ia.cycle_cnt, 0);
    chk("rst_instr", ia.instr_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // load-use: LOAD R1 ; ADD R3,R1,R2
    set_a(1, 1, 2, 0, 0, 1, 1, 1, 0);
    #1 chk("lu_load_nostall", ia.pc_stall, 0);
    tick();
    set_a(1, 1, 1, 1, 2, 1, 3, 0, 0);
    #1;
    chk("lu_pc_stall", ia.pc_stall, 1);
    chk("lu_ifid_stall", ia.ifid_stall, 1);
    chk("lu_bubble", ia.idex_bubble, 1);
    chk("lu_fwd_a_stalled", ia.fwd_a_sel, 0);
    tick();
    #1;
    chk("lu_release", ia.pc_stall, 0);
    chk("lu_fwd_a_mem", ia.fwd_a_sel, 2);
    chk("lu_fwd_b_rf", ia.fwd_b_sel, 0);
    chk("lu_stall_cnt", ia.stall_cnt, 1);
    tick();
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();

    // forwarding priority: ADDI R1 ; ADDI R1 ; ADD R4,R1,R1 ; SUB R5,R1,R2 ; use R1
    set_a(1, 1, 6, 0, 0, 1, 1, 0, 0);
    tick();
    set_a(1, 1, 6, 0, 0, 1, 1, 0, 0);
    tick();
    set_a(1, 1, 1, 1, 1, 1, 4, 0, 0);
    #1;
    chk("fw_a_ex", ia.fwd_a_sel, 1);
    chk("fw_b_ex", ia.fwd_b_sel, 1);
    chk("fw_nostall", ia.pc_stall, 0);
    tick();
    set_a(1, 1, 1, 1, 2, 1, 5, 0, 0);
    #1;
    chk("fw_a_mem", ia.fwd_a_sel, 2);
    chk("fw_b_none", ia.fwd_b_sel, 0);
    tick();
    set_a(1, 1, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("fw_a_wb", ia.fwd_a_sel, 3);
    tick();
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("fw_stall_cnt", ia.stall_cnt, 1);

    // branch overrides a pending load-use
    do_reset();
    set_a(1, 1, 2, 0, 0, 1, 7, 1, 0);
    tick();
    set_a(1, 1, 7, 0, 0, 1, 8, 0, 0);
    ia.ex_br_taken = 1'b1;
    #1;
    chk("br_flush", ia.ifid_flush, 1);
    chk("br_bubble", ia.idex_bubble, 1);
    chk("br_pc_stall", ia.pc_stall, 0);
    chk("br_ifid_stall", ia.ifid_stall, 0);
    tick();
    ia.ex_br_taken = 1'b0;
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("br_stall_cnt", ia.stall_cnt, 0);
    chk("br_branch_cnt", ia.branch_cnt, 1);
    chk("br_cycle_cnt", ia.cycle_cnt, 2);

    // 4 ALU ops then HALT
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_a(1, 0, 0, 0, 0, 1, 5'(10 + i), 0, 0);
      tick();
    end
    set_a(1, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("h_issue_nostall", ia.pc_stall, 0);
    tick();
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ia.ex_br_taken = 1'b1;
    #1;
    chk("h_drain_pc_stall", ia.pc_stall, 1);
    chk("h_drain_flush", ia.ifid_flush, 1);
    chk("h_drain_bubble", ia.idex_bubble, 1);
    tick();
    ia.ex_br_taken = 1'b0;
    #1 chk("h_br_ignored", ia.branch_cnt, 0);
    tick();
    #1 chk("h_not_yet", ia.halted, 0);
    tick();
    #1;
    chk("h_halted", ia.halted, 1);
    chk("h_instr_cnt", ia.instr_cnt, 5);
    chk("h_cycle_cnt", ia.cycle_cnt, 8);
    chk("h_ifid_stall", ia.ifid_stall, 1);
    set_a(1, 1, 1, 0, 0, 1, 2, 0, 0);
    ia.ex_br_taken = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    #1;
    chk("h_frz_cycle", ia.cycle_cnt, 8);
    chk("h_frz_instr", ia.instr_cnt, 5);
    chk("h_frz_branch", ia.branch_cnt, 0);
    chk("h_frz_halted", ia.halted, 1);
    chk("h_frz_pc_stall", ia.pc_stall, 1);

    // reset during DRAIN, then normal operation
    do_reset();
    set_a(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rd_in_drain", ia.pc_stall, 1);
    #1 rst = 1'b1;
    #1;
    chk("rd_pc_stall", ia.pc_stall, 0);
    chk("rd_flush", ia.ifid_flush, 0);
    chk("rd_bubble", ia.idex_bubble, 0);
    chk("rd_cycle", ia.cycle_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    set_a(1, 1, 2, 0, 0, 1, 1, 1, 0);
    tick();
    set_a(1, 1, 1, 0, 0, 1, 3, 0, 0);
    #1 chk("rd_lu_stall", ia.pc_stall, 1);
    tick();
    #1 chk("rd_lu_fwd", ia.fwd_a_sel, 2);
    tick();
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rd_stall_cnt", ia.stall_cnt, 1);
    chk("rd_halted", ia.halted, 0);

    // no forwarding: ADDI R1 ; ADD R3,R1,R2
    do_reset();
    set_b(1, 1, 6, 0, 0, 1, 1, 0, 0);
    tick();
    set_b(1, 1, 1, 1, 2, 1, 3, 0, 0);
    #1;
    chk("nf_stall_ex", ib.pc_stall, 1);
    chk("nf_fwd_a0", ib.fwd_a_sel, 0);
    tick();
    #1;
    chk("nf_stall_mem", ib.pc_stall, 1);
    chk("nf_bubble_mem", ib.idex_bubble, 1);
    tick();
    #1;
    chk("nf_release", ib.pc_stall, 0);
    chk("nf_fwd_a_wb0", ib.fwd_a_sel, 0);
    chk("nf_stall_cnt", ib.stall_cnt, 2);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
